// File: rtl/hyper_boot_sequencer.sv
// hyper_boot_sequencer: staggered HyperRAM power-up, boot-mode dispatch and
// end-of-computation supervision with a global watchdog.
// Optional feature macro: HYPER_BOOT_PROGRESS_EN builds the power-up progress
// reporting (prog_valid_o / prog_idx_o); without it both outputs are tied to 0.
// Handshake note: eoc_valid_i is a plain qualifier with no ready; a word is
// consumed only in WAIT_EOC and only when its done flag (bit 0) is set.
module hyper_boot_sequencer #(
    parameter int unsigned NumChannels   = 2,
    parameter int unsigned PowerupCycles = 100,
    parameter int unsigned StaggerCycles = 10,
    parameter int unsigned NumItvs       = 5,
    parameter int unsigned TimeoutCycles = 1000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             boot_mode_i,
    output logic [NumChannels-1:0] hyp_ready_o,
    output logic                   pwrup_done_o,
    output logic                   prog_valid_o,
    output logic [3:0]             prog_idx_o,
    output logic                   preload_start_o,
    input  logic                   eoc_valid_i,
    input  logic [31:0]            eoc_code_i,
    output logic                   done_o,
    output logic [31:0]            exit_code_o,
    output logic                   fail_o,
    output logic [1:0]             fail_cause_o
);

    localparam int unsigned TotalCycles = (NumChannels - 1) * StaggerCycles + PowerupCycles;
    localparam int unsigned CntW        = $clog2(TotalCycles + 1);
    localparam int unsigned WdW         = $clog2(TimeoutCycles + 1);
    localparam int unsigned ItvLen      = TotalCycles / NumItvs;

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseMode    = 2'd1;
    localparam logic [1:0] CauseTimeout = 2'd2;

    typedef enum logic [2:0] {
        ST_POWERUP  = 3'd0,
        ST_BOOTSEL  = 3'd1,
        ST_PRELOAD  = 3'd2,
        ST_WAIT_EOC = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAIL     = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        pwr_cnt_q, pwr_cnt_d;
    logic [WdW-1:0]         wd_cnt_q, wd_cnt_d;
    logic [NumChannels-1:0] hyp_ready_q, hyp_ready_d;
    logic                   pwrup_done_q, pwrup_done_d;
    logic                   preload_start_q, preload_start_d;
    logic                   done_q, done_d;
    logic [31:0]            exit_code_q, exit_code_d;
    logic                   fail_q, fail_d;
    logic [1:0]             fail_cause_q, fail_cause_d;

    logic pwr_at_total;
    logic wd_expire;
    logic eoc_hit;

    assign pwr_at_total = (pwr_cnt_q == CntW'(TotalCycles));
    assign wd_expire    = (wd_cnt_q == WdW'(TimeoutCycles - 1));
    assign eoc_hit      = eoc_valid_i && eoc_code_i[0];

    // Power-up counter, sticky per-channel ready flags and the all-ready flag.
    always_comb begin
        pwr_cnt_d    = pwr_cnt_q;
        hyp_ready_d  = hyp_ready_q;
        pwrup_done_d = pwrup_done_q;
        if (state_q == ST_POWERUP) begin
            if (!pwr_at_total) begin
                pwr_cnt_d = pwr_cnt_q + CntW'(1);
            end
            for (int c = 0; c < int'(NumChannels); c++) begin
                if (pwr_cnt_q == CntW'(c * StaggerCycles + PowerupCycles)) begin
                    hyp_ready_d[c] = 1'b1;
                end
            end
            if (pwr_at_total) begin
                pwrup_done_d = 1'b1;
            end
        end
    end

    // Sequencer FSM: boot dispatch, EOC capture and watchdog override.
    always_comb begin
        state_d         = state_q;
        wd_cnt_d        = wd_cnt_q;
        preload_start_d = 1'b0;
        done_d          = done_q;
        exit_code_d     = exit_code_q;
        fail_d          = fail_q;
        fail_cause_d    = fail_cause_q;

        case (state_q)
            ST_POWERUP: begin
                if (pwr_at_total) begin
                    state_d = ST_BOOTSEL;
                end
            end
            ST_BOOTSEL: begin
                case (boot_mode_i)
                    2'd0: begin
                        state_d         = ST_PRELOAD;
                        preload_start_d = 1'b1;
                    end
                    2'd1: begin
                        state_d      = ST_FAIL;
                        fail_d       = 1'b1;
                        fail_cause_d = CauseMode;
                    end
                    default: begin
                        state_d = ST_WAIT_EOC;
                    end
                endcase
            end
            ST_PRELOAD: begin
                state_d = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
                if (eoc_hit) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    exit_code_d = {1'b0, eoc_code_i[31:1]};
                end
            end
            default: begin
                // DONE and FAIL hold everything until reset.
            end
        endcase

        // Watchdog runs in every live state; a completing EOC beats expiry.
        if (state_q != ST_DONE && state_q != ST_FAIL) begin
            wd_cnt_d = wd_cnt_q + WdW'(1);
            if (wd_expire && !(state_q == ST_WAIT_EOC && eoc_hit)) begin
                state_d         = ST_FAIL;
                preload_start_d = 1'b0;
                fail_d          = 1'b1;
                fail_cause_d    = CauseTimeout;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_POWERUP;
            pwr_cnt_q       <= '0;
            wd_cnt_q        <= '0;
            hyp_ready_q     <= '0;
            pwrup_done_q    <= 1'b0;
            preload_start_q <= 1'b0;
            done_q          <= 1'b0;
            exit_code_q     <= '0;
            fail_q          <= 1'b0;
            fail_cause_q    <= CauseNone;
        end else begin
            state_q         <= state_d;
            pwr_cnt_q       <= pwr_cnt_d;
            wd_cnt_q        <= wd_cnt_d;
            hyp_ready_q     <= hyp_ready_d;
            pwrup_done_q    <= pwrup_done_d;
            preload_start_q <= preload_start_d;
            done_q          <= done_d;
            exit_code_q     <= exit_code_d;
            fail_q          <= fail_d;
            fail_cause_q    <= fail_cause_d;
        end
    end

`ifdef HYPER_BOOT_PROGRESS_EN
    logic       prog_valid_q, prog_valid_d;
    logic [3:0] prog_idx_q, prog_idx_d;

    // Progress pulse one cycle after each interval boundary; the last interval
    // ends at the full power-up time so it lines up with pwrup_done_o.
    always_comb begin
        prog_valid_d = 1'b0;
        prog_idx_d   = 4'd0;
        if (state_q == ST_POWERUP) begin
            for (int k = 1; k < int'(NumItvs); k++) begin
                if (pwr_cnt_q == CntW'(k * ItvLen)) begin
                    prog_valid_d = 1'b1;
                    prog_idx_d   = 4'(k);
                end
            end
            if (pwr_at_total) begin
                prog_valid_d = 1'b1;
                prog_idx_d   = 4'(NumItvs);
            end
        end
    end

    // Progress registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prog_valid_q <= 1'b0;
            prog_idx_q   <= 4'd0;
        end else begin
            prog_valid_q <= prog_valid_d;
            prog_idx_q   <= prog_idx_d;
        end
    end

    assign prog_valid_o = prog_valid_q;
    assign prog_idx_o   = prog_idx_q;
`else
    assign prog_valid_o = 1'b0;
    assign prog_idx_o   = 4'd0;
`endif

    assign hyp_ready_o     = hyp_ready_q;
    assign pwrup_done_o    = pwrup_done_q;
    assign preload_start_o = preload_start_q;
    assign done_o          = done_q;
    assign exit_code_o     = exit_code_q;
    assign fail_o          = fail_q;
    assign fail_cause_o    = fail_cause_q;

endmodule
